exec_dispatch: RTL

Parametrised execute-stage dispatcher. It sits between decode and writeback, replacing the fixed four-way single-cycle arbiter. It steers each decoded instruction to one of N_UNITS functional units, which may be multi-cycle, and tracks program order in a unit-ID FIFO. Results retire strictly in order through a result port that, unlike the previous stage, honours backpressure.

---
 rtl/exec_dispatch.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/exec_dispatch.sv
// exec_dispatch: execute-stage dispatcher. Steers decoded instructions to
// N_UNITS (possibly multi-cycle) functional units and retires their results
// strictly in program order, using a FIFO of unit indices to track order.
// Per-unit outstanding counters bound how many ops each unit holds at once.

module exec_dispatch #(
    parameter int N_UNITS  = 4,
    parameter int DEPTH    = 4,
    parameter int UNIT_MAX = 2,
    parameter int INSTR_W  = 96,
    parameter int RES_W    = 64,
    parameter int UID_W    = $clog2(N_UNITS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [INSTR_W-1:0]           i_in_data,
    input  logic [UID_W-1:0]             i_in_unit,
    output logic [N_UNITS-1:0]           o_unit_valid,
    input  logic [N_UNITS-1:0]           i_unit_ready,
    output logic [INSTR_W-1:0]           o_unit_data,
    input  logic [N_UNITS-1:0]           i_unit_res_valid,
    output logic [N_UNITS-1:0]           o_unit_res_ready,
    input  logic [N_UNITS*RES_W-1:0]     i_unit_res_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [RES_W-1:0]             o_out_data,
    output logic [UID_W-1:0]             o_out_unit,
    output logic [$clog2(DEPTH+1)-1:0]   o_inflight,
    output logic                         o_bad_unit
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OC_W  = $clog2(UNIT_MAX + 1);

    // Order FIFO holds the unit index of every in-flight instruction.
    logic [UID_W-1:0] r_fifo [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic [OC_W-1:0]  r_ocnt [N_UNITS];
    logic             r_bad;

    logic             w_unit_ok;
    logic             w_tgt_ready;
    logic             w_tgt_room;
    logic             w_dispatch_ok;
    logic             w_accept;
    logic [UID_W-1:0] w_head;
    logic             w_head_valid;
    logic             w_retire;
    logic [CNT_W-1:0] w_count_nxt;
    logic [OC_W-1:0]  w_ocnt_nxt [N_UNITS];

    // Look up readiness and spare capacity of the requested target unit.
    always_comb begin
        w_unit_ok   = (32'(i_in_unit) < N_UNITS);
        w_tgt_ready = 1'b0;
        w_tgt_room  = 1'b0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (i_in_unit == UID_W'(i)) begin
                w_tgt_ready = i_unit_ready[i];
                w_tgt_room  = (32'(r_ocnt[i]) < UNIT_MAX);
            end
        end
    end

    // Dispatch decision; deliberately independent of i_out_ready.
    always_comb begin
        w_dispatch_ok = i_rst && !i_flush && (32'(r_count) < DEPTH) &&
                        w_unit_ok && w_tgt_ready && w_tgt_room;
        w_accept      = i_in_valid && w_dispatch_ok;
        o_in_ready    = w_dispatch_ok;
        o_unit_valid  = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (w_accept && (i_in_unit == UID_W'(i))) begin
                o_unit_valid[i] = 1'b1;
            end
        end
    end

    assign o_unit_data = i_in_data;

    // In-order retire: only the unit at the FIFO head may present a result.
    always_comb begin
        w_head       = r_fifo[r_rd];
        w_head_valid = 1'b0;
        o_out_data   = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (w_head == UID_W'(i)) begin
                w_head_valid = i_unit_res_valid[i];
                o_out_data   = i_unit_res_data[i*RES_W +: RES_W];
            end
        end
        o_out_valid      = (r_count != '0) && w_head_valid && !i_flush;
        w_retire         = o_out_valid && i_out_ready;
        o_out_unit       = w_head;
        o_unit_res_ready = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (w_retire && (w_head == UID_W'(i))) begin
                o_unit_res_ready[i] = 1'b1;
            end
        end
    end

    // Next occupancy and per-unit counts; accept+retire on one unit cancels.
    always_comb begin
        w_count_nxt = r_count;
        if (w_accept && !w_retire) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_retire && !w_accept) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
        for (int i = 0; i < N_UNITS; i++) begin
            w_ocnt_nxt[i] = r_ocnt[i];
            if (o_unit_valid[i] && !o_unit_res_ready[i]) begin
                w_ocnt_nxt[i] = r_ocnt[i] + OC_W'(1);
            end else if (o_unit_res_ready[i] && !o_unit_valid[i]) begin
                w_ocnt_nxt[i] = r_ocnt[i] - OC_W'(1);
            end
        end
    end

    // State update: reset beats flush; flush drops in-flight work but keeps bad_unit.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_bad   <= 1'b0;
            for (int i = 0; i < N_UNITS; i++) begin
                r_ocnt[i] <= '0;
            end
            for (int d = 0; d < DEPTH; d++) begin
                r_fifo[d] <= '0;
            end
        end else begin
            if (i_in_valid && !w_unit_ok) begin
                r_bad <= 1'b1;
            end
            if (i_flush) begin
                r_wr    <= '0;
                r_rd    <= '0;
                r_count <= '0;
                for (int i = 0; i < N_UNITS; i++) begin
                    r_ocnt[i] <= '0;
                end
            end else begin
                if (w_accept) begin
                    r_fifo[r_wr] <= i_in_unit;
                    r_wr         <= r_wr + PTR_W'(1);
                end
                if (w_retire) begin
                    r_rd <= r_rd + PTR_W'(1);
                end
                r_count <= w_count_nxt;
                for (int i = 0; i < N_UNITS; i++) begin
                    r_ocnt[i] <= w_ocnt_nxt[i];
                end
            end
        end
    end

    assign o_inflight = r_count;
    assign o_bad_unit = r_bad;

endmodule
